// File: rtl/ch0re_ifetch_buf_if.sv
// Fetch-buffer bus: instruction-memory read port, EX redirect, and the decode-side valid/ready head.
interface ch0re_ifetch_buf_if #(
  parameter int IMEM_ADDR_WIDTH = 12
);
  logic                       o_imem_req;
  logic [IMEM_ADDR_WIDTH-1:0] o_imem_addr;
  logic [31:0]                i_imem_rdata;
  logic                       i_redirect;
  logic [63:0]                i_redirect_pc;
  logic                       o_valid;
  logic                       i_ready;
  logic [31:0]                o_instr;
  logic [63:0]                o_pc;
  logic                       o_misalign;

  modport master (
    output o_imem_req, o_imem_addr, o_valid, o_instr, o_pc, o_misalign,
    input  i_imem_rdata, i_redirect, i_redirect_pc, i_ready
  );

  modport slave (
    input  o_imem_req, o_imem_addr, o_valid, o_instr, o_pc, o_misalign,
    output i_imem_rdata, i_redirect, i_redirect_pc, i_ready
  );
endinterface

// File: rtl/ch0re_ifetch_buf.sv
// Fetch PC + prefetch FIFO: 2-cycle request-to-valid, credit-limited reads so the FIFO never overflows.
// CH0RE_IFETCH_MISALIGN_EN: misaligned fetch PC pushes one flagged NOP and stalls until redirect.
module ch0re_ifetch_buf #(
  parameter int          DEPTH           = 4,
  parameter logic [63:0] RESET_PC        = 64'h150,
  parameter int          IMEM_ADDR_WIDTH = 12
) (
  input logic                clk,
  input logic                rst_n,
  ch0re_ifetch_buf_if.master bus
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam int OW = CW + 1;

  typedef struct packed {
    logic [31:0] instr;
    logic [63:0] pc;
    logic        misalign;
  } entry_t;

  entry_t        mem_q [DEPTH];
  logic [63:0]   fetch_pc_q, fetch_pc_d;
  logic [63:0]   inflight_pc_q, inflight_pc_d;
  logic          inflight_q, inflight_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          halt_q;

  logic          valid, pop, credit, can_issue, req, mis_push, push;
  logic [OW-1:0] occ;
  entry_t        push_dat, head;

  assign valid = (count_q != '0);
  assign pop   = valid & bus.i_ready;

  // Slots already committed (stored + outstanding) after this cycle's pop.
  assign occ       = OW'(count_q) + OW'(inflight_q) - OW'(pop);
  assign credit    = (occ < OW'(DEPTH));
  assign can_issue = rst_n & ~bus.i_redirect & ~halt_q & credit;

`ifdef CH0RE_IFETCH_MISALIGN_EN
  logic misaligned, halt_d;
  assign misaligned = (fetch_pc_q[1:0] != 2'b00);
  assign req        = can_issue & ~misaligned;
  assign mis_push   = can_issue & misaligned & ~inflight_q;

  always_comb begin
    halt_d = halt_q;
    if (bus.i_redirect)  halt_d = 1'b0;
    else if (mis_push)   halt_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) halt_q <= 1'b0;
    else        halt_q <= halt_d;
  end
`else
  assign req      = can_issue;
  assign mis_push = 1'b0;
  assign halt_q   = 1'b0;
`endif

  assign push = (inflight_q & ~bus.i_redirect) | mis_push;

  always_comb begin
    push_dat.instr    = bus.i_imem_rdata;
    push_dat.pc       = inflight_pc_q;
    push_dat.misalign = 1'b0;
    if (mis_push) begin
      push_dat.instr    = 32'h0000_0013;
      push_dat.pc       = fetch_pc_q;
      push_dat.misalign = 1'b1;
    end
  end

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    inflight_pc_d = inflight_pc_q;
    inflight_d    = 1'b0;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    count_d       = count_q;
    if (bus.i_redirect) begin
      fetch_pc_d = bus.i_redirect_pc;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
    end else begin
      if (req) begin
        inflight_d    = 1'b1;
        inflight_pc_d = fetch_pc_q;
        fetch_pc_d    = fetch_pc_q + 64'd4;
      end
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q    <= RESET_PC;
      inflight_pc_q <= '0;
      inflight_q    <= 1'b0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      inflight_pc_q <= inflight_pc_d;
      inflight_q    <= inflight_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_dat;
  end

  assign head            = mem_q[rd_ptr_q];
  assign bus.o_imem_req  = req;
  assign bus.o_imem_addr = fetch_pc_q[IMEM_ADDR_WIDTH+1:2];
  assign bus.o_valid     = valid;
  assign bus.o_instr     = valid ? head.instr : 32'h0;
  assign bus.o_pc        = valid ? head.pc : 64'h0;
  assign bus.o_misalign  = valid & head.misalign;

endmodule
